// File: rtl/wb_burst_split.sv
// Wishbone burst splitter: turns an upstream burst into single-beat downstream accesses.
// Define WB_BURST_SPLIT_TIMEOUT_EN to compile in the downstream no-ack watchdog.
module wb_burst_split #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] wbm_dat_i,
  input  logic [31:0] wbm_adr_i,
  input  logic [3:0]  wbm_sel_i,
  input  logic [9:0]  wbm_bl_i,
  input  logic        wbm_bry_i,
  input  logic        wbm_we_i,
  input  logic        wbm_cyc_i,
  input  logic        wbm_stb_i,
  output logic [31:0] wbm_dat_o,
  output logic        wbm_ack_o,
  output logic        wbm_lack_o,
  output logic        wbm_err_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] wbs_adr_o,
  output logic [3:0]  wbs_sel_o,
  output logic        wbs_we_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    NEXT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        beat_req;
  logic        accept_first;
  logic        accept_next;
  logic        timeout;
  logic        ack_d;
  logic        lack_d;
  logic        err_d;
  logic        abort_q;
  logic        abort_nxt;
  logic [9:0]  cnt_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [31:0] rdat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        ack_q;
  logic        lack_q;
  logic        err_q;

  assign beat_req = wbm_cyc_i & wbm_stb_i & wbm_bry_i;

`ifdef WB_BURST_SPLIT_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= 32'd0;
    end else if (accept_first || accept_next) begin
      to_cnt_q <= 32'd0;
    end else if (state == ACCESS) begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end

  assign timeout = (state == ACCESS) && !wbs_ack_i && !wbs_err_i &&
                   (to_cnt_q == TIMEOUT_CYC - 32'd1);
`else
  // TIMEOUT_CYC is referenced only so the parameter list is identical in both builds.
  assign timeout = (TIMEOUT_CYC == 32'd0) & 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accept_first = 1'b0;
    accept_next  = 1'b0;
    ack_d        = 1'b0;
    lack_d       = 1'b0;
    err_d        = 1'b0;
    case (state)
      IDLE: begin
        if (beat_req) begin
          accept_first = 1'b1;
          state_nxt    = ACCESS;
        end
      end
      ACCESS: begin
        // An access whose upstream cycle went away still finishes, but silently.
        if (wbs_ack_i || wbs_err_i || timeout) begin
          if (abort_q || !wbm_cyc_i) begin
            state_nxt = IDLE;
          end else if (wbs_err_i || timeout) begin
            err_d     = 1'b1;
            lack_d    = 1'b1;
            state_nxt = DONE;
          end else begin
            ack_d     = 1'b1;
            lack_d    = (cnt_q == 10'd1);
            state_nxt = (cnt_q == 10'd1) ? DONE : NEXT;
          end
        end
      end
      NEXT: begin
        if (!wbm_cyc_i) begin
          state_nxt = IDLE;
        end else if (beat_req) begin
          accept_next = 1'b1;
          state_nxt   = ACCESS;
        end
      end
      DONE: begin
        if (!wbm_stb_i || !wbm_cyc_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign abort_nxt = (state == ACCESS) && (state_nxt == ACCESS) && (abort_q || !wbm_cyc_i);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      lack_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= 10'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      rdat_q  <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      lack_q  <= lack_d;
      err_q   <= err_d;
      abort_q <= abort_nxt;
      if (accept_first) begin
        adr_q <= wbm_adr_i & 32'hFFFF_FFFC;
        sel_q <= wbm_sel_i;
        we_q  <= wbm_we_i;
        cnt_q <= (wbm_bl_i == 10'd0) ? 10'd1 : wbm_bl_i;
        dat_q <= wbm_dat_i;
      end
      // Word address advances modulo 2^30, so the byte address wraps to 0.
      if (accept_next) begin
        adr_q <= adr_q + 32'd4;
        dat_q <= wbm_dat_i;
      end
      if (ack_d) begin
        cnt_q  <= cnt_q - 10'd1;
        rdat_q <= wbs_dat_i;
      end
    end
  end

  assign wbm_dat_o  = rdat_q;
  assign wbm_ack_o  = ack_q;
  assign wbm_lack_o = lack_q;
  assign wbm_err_o  = err_q;
  assign wbs_dat_o  = dat_q;
  assign wbs_adr_o  = adr_q;
  assign wbs_sel_o  = sel_q;
  assign wbs_we_o   = we_q;
  assign wbs_stb_o  = (state == ACCESS);
  assign wbs_cyc_o  = (state == ACCESS) || (state == NEXT);

endmodule

// File: tb/tb_wb_burst_split.sv
// Directed self-checking bench for wb_burst_split; inputs driven and outputs sampled on negedge.
module tb_wb_burst_split;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [31:0] wbm_dat_i, wbm_adr_i;
  logic [3:0]  wbm_sel_i;
  logic [9:0]  wbm_bl_i;
  logic        wbm_bry_i, wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_o, wbm_lack_o, wbm_err_o;
  logic [31:0] wbs_dat_o, wbs_adr_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_i, wbs_err_i;

  int tests_run = 0;
  int tests_failed = 0;

  wb_burst_split #(.TIMEOUT_CYC(16)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .wbm_dat_i(wbm_dat_i), .wbm_adr_i(wbm_adr_i), .wbm_sel_i(wbm_sel_i),
    .wbm_bl_i(wbm_bl_i), .wbm_bry_i(wbm_bry_i), .wbm_we_i(wbm_we_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_lack_o(wbm_lack_o),
    .wbm_err_o(wbm_err_o),
    .wbs_dat_o(wbs_dat_o), .wbs_adr_o(wbs_adr_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic start_burst(input logic [31:0] adr, input logic [9:0] bl,
                             input logic we, input logic [31:0] dat);
    wbm_adr_i = adr; wbm_bl_i = bl; wbm_we_i = we; wbm_dat_i = dat;
    wbm_sel_i = 4'hF; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_bry_i = 1'b1;
  endtask

  task automatic end_burst();
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_bry_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wbm_dat_i = 32'h0; wbm_adr_i = 32'h0; wbm_sel_i = 4'h0; wbm_bl_i = 10'd0;
    wbm_we_i = 1'b0; end_burst();
    wbs_dat_i = 32'h0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    tests_run++;
    if ({wbm_dat_o, wbm_ack_o, wbm_lack_o, wbm_err_o, wbs_dat_o, wbs_adr_o, wbs_sel_o,
         wbs_we_o, wbs_cyc_o, wbs_stb_o} !== 106'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got adr=%h stb=%b ack=%b, want all zero",
               wbs_adr_o, wbs_stb_o, wbm_ack_o);
    end
    rst_n = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if ({wbs_cyc_o, wbs_stb_o, wbm_ack_o} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: got cyc/stb/ack=%b want 000",
               {wbs_cyc_o, wbs_stb_o, wbm_ack_o});
    end
  endtask

  task automatic test_single_write();
    start_burst(32'h1000_0006, 10'd1, 1'b1, 32'hA5A5_5A5A);
    @(negedge clk_i);
    wbm_dat_i = 32'hDEAD_BEEF;
    tests_run++;
    if ({wbs_cyc_o, wbs_stb_o, wbs_we_o} !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL sw_strobe: got cyc/stb/we=%b want 111", {wbs_cyc_o, wbs_stb_o, wbs_we_o});
    end
    tests_run++;
    if (wbs_adr_o !== 32'h1000_0004) begin
      tests_failed++;
      $display("[TB] FAIL sw_adr: got %h want 10000004", wbs_adr_o);
    end
    tests_run++;
    if (wbs_dat_o !== 32'hA5A5_5A5A) begin
      tests_failed++;
      $display("[TB] FAIL sw_dat: got %h want a5a55a5a", wbs_dat_o);
    end
    @(negedge clk_i);
    tests_run++;
    if ({wbs_stb_o, wbm_ack_o} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL sw_wait: got stb/ack=%b want 10", {wbs_stb_o, wbm_ack_o});
    end
    wbs_ack_i = 1'b1; wbs_dat_i = 32'h1234_5678;
    @(negedge clk_i);
    wbs_ack_i = 1'b0;
    tests_run++;
    if ({wbm_ack_o, wbm_lack_o, wbm_err_o, wbs_stb_o} !== 4'b1100) begin
      tests_failed++;
      $display("[TB] FAIL sw_resp: got ack/lack/err/stb=%b want 1100",
               {wbm_ack_o, wbm_lack_o, wbm_err_o, wbs_stb_o});
    end
    tests_run++;
    if (wbm_dat_o !== 32'h1234_5678) begin
      tests_failed++;
      $display("[TB] FAIL sw_rdat: got %h want 12345678", wbm_dat_o);
    end
    end_burst();
    @(negedge clk_i);
    tests_run++;
    if ({wbm_ack_o, wbm_lack_o, wbs_cyc_o} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL sw_pulse_end: got ack/lack/cyc=%b want 000",
               {wbm_ack_o, wbm_lack_o, wbs_cyc_o});
    end
  endtask

  task automatic test_read_burst();
    logic [31:0] exp_adr;
    start_burst(32'h2000_0000, 10'd4, 1'b0, 32'h0);
    for (int b = 0; b < 4; b++) begin
      exp_adr = 32'h2000_0000 + 32'(4 * b);
      @(negedge clk_i);
      tests_run++;
      if ({wbs_stb_o, wbs_we_o, wbs_adr_o} !== {2'b10, exp_adr}) begin
        tests_failed++;
        $display("[TB] FAIL rd_beat%0d_req: got stb/we=%b adr=%h want 10 adr=%h",
                 b, {wbs_stb_o, wbs_we_o}, wbs_adr_o, exp_adr);
      end
      wbs_ack_i = 1'b1; wbs_dat_i = 32'hC0DE_0000 + 32'(b);
      @(negedge clk_i);
      wbs_ack_i = 1'b0;
      tests_run++;
      if ({wbm_ack_o, wbm_lack_o, wbs_stb_o, wbs_cyc_o} !== {1'b1, (b == 3), 1'b0, (b != 3)}) begin
        tests_failed++;
        $display("[TB] FAIL rd_beat%0d_resp: got ack/lack/stb/cyc=%b want %b", b,
                 {wbm_ack_o, wbm_lack_o, wbs_stb_o, wbs_cyc_o}, {1'b1, (b == 3), 1'b0, (b != 3)});
      end
      tests_run++;
      if (wbm_dat_o !== 32'hC0DE_0000 + 32'(b)) begin
        tests_failed++;
        $display("[TB] FAIL rd_beat%0d_dat: got %h want %h", b, wbm_dat_o, 32'hC0DE_0000 + 32'(b));
      end
    end
    end_burst();
    @(negedge clk_i);
    tests_run++;
    if ({wbm_ack_o, wbs_cyc_o, wbs_stb_o} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL rd_end: got ack/cyc/stb=%b want 000", {wbm_ack_o, wbs_cyc_o, wbs_stb_o});
    end
  endtask

  task automatic test_throttled_write();
    int gap_bad;
    start_burst(32'h3000_0010, 10'd3, 1'b1, 32'h1111_0000);
    @(negedge clk_i);
    tests_run++;
    if ({wbs_stb_o, wbs_dat_o} !== {1'b1, 32'h1111_0000}) begin
      tests_failed++;
      $display("[TB] FAIL thr_beat1: got stb=%b dat=%h want 1 11110000", wbs_stb_o, wbs_dat_o);
    end
    wbs_ack_i = 1'b1;
    @(negedge clk_i);
    wbs_ack_i = 1'b0;
    tests_run++;
    if ({wbm_ack_o, wbm_lack_o} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL thr_ack1: got ack/lack=%b want 10", {wbm_ack_o, wbm_lack_o});
    end
    wbm_bry_i = 1'b0; wbm_dat_i = 32'hBAD0_BAD0;
    gap_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if ({wbs_stb_o, wbs_cyc_o, wbm_ack_o} !== 3'b010) gap_bad++;
    end
    tests_run++;
    if (gap_bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL thr_gap: got %0d bad gap cycles want 0", gap_bad);
    end
    wbm_bry_i = 1'b1; wbm_dat_i = 32'h2222_1111;
    @(negedge clk_i);
    tests_run++;
    if ({wbs_stb_o, wbs_dat_o, wbs_adr_o} !== {1'b1, 32'h2222_1111, 32'h3000_0014}) begin
      tests_failed++;
      $display("[TB] FAIL thr_beat2: got stb=%b dat=%h adr=%h want 1 22221111 30000014",
               wbs_stb_o, wbs_dat_o, wbs_adr_o);
    end
    wbm_dat_i = 32'h3333_2222; wbs_ack_i = 1'b1;
    @(negedge clk_i);
    wbs_ack_i = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if ({wbs_dat_o, wbs_adr_o} !== {32'h3333_2222, 32'h3000_0018}) begin
      tests_failed++;
      $display("[TB] FAIL thr_beat3: got dat=%h adr=%h want 33332222 30000018", wbs_dat_o, wbs_adr_o);
    end
    wbs_ack_i = 1'b1;
    @(negedge clk_i);
    wbs_ack_i = 1'b0;
    tests_run++;
    if ({wbm_ack_o, wbm_lack_o} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL thr_last: got ack/lack=%b want 11", {wbm_ack_o, wbm_lack_o});
    end
    end_burst();
    @(negedge clk_i);
  endtask

  task automatic test_error_wrap();
    start_burst(32'hFFFF_FFFC, 10'd3, 1'b0, 32'h0);
    @(negedge clk_i);
    tests_run++;
    if (wbs_adr_o !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("[TB] FAIL wrap_beat1_adr: got %h want fffffffc", wbs_adr_o);
    end
    wbs_ack_i = 1'b1;
    @(negedge clk_i);
    wbs_ack_i = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if ({wbs_stb_o, wbs_adr_o} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL wrap_beat2_adr: got stb=%b adr=%h want 1 00000000", wbs_stb_o, wbs_adr_o);
    end
    wbs_err_i = 1'b1;
    @(negedge clk_i);
    wbs_err_i = 1'b0;
    tests_run++;
    if ({wbm_err_o, wbm_lack_o, wbm_ack_o, wbs_stb_o} !== 4'b1100) begin
      tests_failed++;
      $display("[TB] FAIL err_resp: got err/lack/ack/stb=%b want 1100",
               {wbm_err_o, wbm_lack_o, wbm_ack_o, wbs_stb_o});
    end
    @(negedge clk_i);
    tests_run++;
    if ({wbm_err_o, wbm_lack_o, wbs_stb_o, wbs_cyc_o} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL err_no_beat3: got err/lack/stb/cyc=%b want 0000",
               {wbm_err_o, wbm_lack_o, wbs_stb_o, wbs_cyc_o});
    end
    wbm_stb_i = 1'b0;
    @(negedge clk_i);
    start_burst(32'h4000_0000, 10'd0, 1'b0, 32'h0);
    @(negedge clk_i);
    tests_run++;
    if ({wbs_stb_o, wbs_adr_o} !== {1'b1, 32'h4000_0000}) begin
      tests_failed++;
      $display("[TB] FAIL bl0_req: got stb=%b adr=%h want 1 40000000", wbs_stb_o, wbs_adr_o);
    end
    wbs_ack_i = 1'b1;
    @(negedge clk_i);
    wbs_ack_i = 1'b0;
    tests_run++;
    if ({wbm_ack_o, wbm_lack_o} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL bl0_single: got ack/lack=%b want 11", {wbm_ack_o, wbm_lack_o});
    end
    end_burst();
    @(negedge clk_i);
  endtask

  task automatic test_abort_reset();
    start_burst(32'h5000_0000, 10'd4, 1'b0, 32'h0);
    @(negedge clk_i);
    wbs_ack_i = 1'b1; wbm_bry_i = 1'b0;
    @(negedge clk_i);
    wbs_ack_i = 1'b0;
    tests_run++;
    if ({wbm_ack_o, wbs_stb_o, wbs_cyc_o} !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL abort_hold: got ack/stb/cyc=%b want 101", {wbm_ack_o, wbs_stb_o, wbs_cyc_o});
    end
    end_burst();
    @(negedge clk_i);
    tests_run++;
    if ({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_lack_o, wbm_err_o} !== 5'b00000) begin
      tests_failed++;
      $display("[TB] FAIL abort_next: got cyc/stb/ack/lack/err=%b want 00000",
               {wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_lack_o, wbm_err_o});
    end
    start_burst(32'h7000_0000, 10'd2, 1'b0, 32'h0);
    @(negedge clk_i);
    end_burst();
    @(negedge clk_i);
    tests_run++;
    if (wbs_stb_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_access_hold: got stb=%b want 1", wbs_stb_o);
    end
    wbs_ack_i = 1'b1;
    @(negedge clk_i);
    wbs_ack_i = 1'b0; wbs_err_i = 1'b1;
    tests_run++;
    if ({wbm_ack_o, wbm_lack_o, wbs_cyc_o} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL abort_access_drop: got ack/lack/cyc=%b want 000",
               {wbm_ack_o, wbm_lack_o, wbs_cyc_o});
    end
    @(negedge clk_i);
    wbs_err_i = 1'b0;
    tests_run++;
    if ({wbm_err_o, wbm_lack_o} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL idle_err_ignored: got err/lack=%b want 00", {wbm_err_o, wbm_lack_o});
    end
    start_burst(32'h6000_0000, 10'd2, 1'b1, 32'h7777_8888);
    @(negedge clk_i);
    tests_run++;
    if ({wbs_stb_o, wbs_we_o} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL rst_pre: got stb/we=%b want 11", {wbs_stb_o, wbs_we_o});
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({wbm_dat_o, wbm_ack_o, wbm_lack_o, wbm_err_o, wbs_dat_o, wbs_adr_o, wbs_sel_o,
         wbs_we_o, wbs_cyc_o, wbs_stb_o} !== 106'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_async: got stb=%b adr=%h dat=%h want all zero",
               wbs_stb_o, wbs_adr_o, wbs_dat_o);
    end
    @(negedge clk_i);
    tests_run++;
    if ({wbs_cyc_o, wbs_stb_o, wbs_adr_o} !== 34'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_hold: got cyc/stb=%b adr=%h want 0", {wbs_cyc_o, wbs_stb_o}, wbs_adr_o);
    end
    end_burst();
    rst_n = 1'b1;
    @(negedge clk_i);
    start_burst(32'h8000_0008, 10'd1, 1'b0, 32'h0);
    @(negedge clk_i);
    tests_run++;
    if ({wbs_stb_o, wbs_adr_o} !== {1'b1, 32'h8000_0008}) begin
      tests_failed++;
      $display("[TB] FAIL post_rst_req: got stb=%b adr=%h want 1 80000008", wbs_stb_o, wbs_adr_o);
    end
    wbs_ack_i = 1'b1;
    @(negedge clk_i);
    wbs_ack_i = 1'b0;
    tests_run++;
    if ({wbm_ack_o, wbm_lack_o} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL post_rst_resp: got ack/lack=%b want 11", {wbm_ack_o, wbm_lack_o});
    end
    end_burst();
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    int hi_cnt;
    hi_cnt = 0;
    start_burst(32'h9000_0000, 10'd2, 1'b0, 32'h0);
`ifdef WB_BURST_SPLIT_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      if (wbs_stb_o === 1'b1) hi_cnt++;
    end
    tests_run++;
    if (hi_cnt !== 16) begin
      tests_failed++;
      $display("[TB] FAIL to_wait: got %0d strobe cycles want 16", hi_cnt);
    end
    @(negedge clk_i);
    tests_run++;
    if ({wbs_stb_o, wbs_cyc_o, wbm_err_o, wbm_lack_o, wbm_ack_o} !== 5'b00110) begin
      tests_failed++;
      $display("[TB] FAIL to_fire: got stb/cyc/err/lack/ack=%b want 00110",
               {wbs_stb_o, wbs_cyc_o, wbm_err_o, wbm_lack_o, wbm_ack_o});
    end
    end_burst();
    @(negedge clk_i);
    tests_run++;
    if ({wbm_err_o, wbm_lack_o} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL to_once: got err/lack=%b want 00", {wbm_err_o, wbm_lack_o});
    end
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (wbs_stb_o === 1'b1 && wbm_err_o === 1'b0) hi_cnt++;
    end
    tests_run++;
    if (hi_cnt !== 40) begin
      tests_failed++;
      $display("[TB] FAIL no_to_wait: got %0d strobe cycles want 40", hi_cnt);
    end
    wbs_ack_i = 1'b1;
    @(negedge clk_i);
    wbs_ack_i = 1'b0;
    end_burst();
    tests_run++;
    if ({wbm_ack_o, wbm_lack_o, wbm_err_o} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL no_to_ack: got ack/lack/err=%b want 100", {wbm_ack_o, wbm_lack_o, wbm_err_o});
    end
    @(negedge clk_i);
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_throttled_write();
    test_error_wrap();
    test_abort_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
